console_io: RTL and testbench
=============================

# console_io

Memory-mapped console and GPIO peripheral on the ulisp core's register port. It generalises the character-at-index-0 console into a real 8N1 UART with parametrised TX/RX FIFOs, sticky error flags, a free-running cycle counter and N 16-bit GPIO output registers. It sits beside ulisp at top level, driven by the core's register_* signals.

## Interface
- TX_DEPTH, 16: TX FIFO entries; power of two, 2..256.
- RX_DEPTH, 16: RX FIFO entries; power of two, 2..256.
- CLKS_PER_BIT, 868: clk cycles per UART bit; at least 4.
- NUM_GPIO, 2: GPIO output registers; 1..8.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- register_index  in  7  register select.
- register_read  in  1  read strobe, one cycle.
- register_write  in  1  write strobe, one cycle.
- register_write_value  in  16  write data.
- register_read_value  out  16  registered read data.
- uart_tx  out  1  serial out, idle high.
- uart_rx  in  1  serial in, asynchronous.
- gpio_out  out  16*NUM_GPIO  GPIO register k at bits [16k+15:16k].

## Operation
- Register map:
  - Index 0: write pushes value[7:0] to the TX FIFO. Read pops the RX FIFO and returns {8'h00, byte}. If the RX FIFO is empty, the read returns 16'hFFFF and does not pop.
  - Index 1 (status), read-only bits:
    - bit0 tx_full; bit1 tx_empty; bit2 rx_valid.
    - bit3 tx_overflow, bit4 rx_overflow, bit5 framing_error: sticky, write-1-to-clear.
    - [15:8] TX FIFO level.
  - Index 2: read returns the 16-bit free-running cycle counter, which wraps. Writes are ignored.
  - Index 3..3+NUM_GPIO-1: read/write GPIO registers.
  - All other indices: read returns 0; writes are ignored.
- TX FIFO push when full: byte dropped, tx_overflow set. A push is accepted if the TX engine pops on the same edge.
- TX FSM states: IDLE, START, DATA (bits LSB first), STOP.
  - IDLE pops when the FIFO is non-empty.
  - Each state lasts CLKS_PER_BIT cycles.
  - At the end of STOP: go to START if the FIFO is non-empty (zero idle gap), else IDLE.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - FSM states: IDLE, START, DATA, STOP.
  - A falling edge starts a frame. The start bit is re-sampled at CLKS_PER_BIT/2; if it is high, return to IDLE (glitch).
  - Data and stop bits are sampled at their mid-points.
  - Stop bit 0: byte discarded, framing_error set.
  - RX FIFO full when a byte completes: byte discarded, rx_overflow set.
  - A CPU pop on the same edge as a push is accepted and leaves the level unchanged.
- If register_read and register_write are both high, the write takes effect and the read returns the value from before the edge.

## Timing
- Reset values:
  - register_read_value = 0, uart_tx = 1, gpio_out = 0.
  - FIFOs empty, flags 0, counter 0, both FSMs IDLE.
  - Reset mid-frame forces uart_tx high immediately (asynchronous).
- register_read_value updates on the edge where register_read is high and holds otherwise. Data is valid the cycle after the strobe.
- A write accepted at edge N is visible to reads from edge N+1. gpio_out changes at edge N.
- A TX byte written at edge N into an idle TX path: uart_tx falls at edge N+1. The frame is exactly 10*CLKS_PER_BIT cycles.
- RX: a byte whose stop mid-point is sampled at edge M is readable (rx_valid=1) from edge M+1. Input-to-sample latency includes 2 synchroniser cycles.
- Status reflects state before the read edge. A W1C write on the same edge as a new error event leaves the flag set.

## Structure
- console_io_pkg holds:
  - register index constants (REG_CONSOLE=0, REG_STATUS=1, REG_CYCLES=2, REG_GPIO_BASE=3);
  - status bit positions;
  - the UART FSM state enum.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push, pop, full, empty and level. It is instantiated for TX and RX with WIDTH=8.

## Test plan
All scenarios run with CLKS_PER_BIT=4, TX_DEPTH=4, RX_DEPTH=4.
- Write 0x41 to index 0 → uart_tx goes low one cycle later, then emits LSB-first 1,0,0,0,0,0,1,0 and stop 1, 40 cycles total. Status then reads bit1=1.
- 6 back-to-back writes 0x30..0x35 → 5 are accepted (one is popped immediately) and the 6th is dropped with status bit3=1. Frames are contiguous with no idle gap. Writing 0x0008 to index 1 clears bit3.
- Drive RX frame 0x5A → read index 1 gives bit2=1; read index 0 gives 0x005A; the next read of index 0 gives 0xFFFF.
- Drive an RX frame with stop bit 0 → bit5 set, FIFO stays empty. A 1-cycle low glitch on uart_rx → nothing received.
- Drive 5 RX frames with no reads → 4 bytes are stored and bit4 is set. Reading gives the first 4 bytes in order.
- Write 0xBEEF to index 4 → gpio_out[31:16]=0xBEEF; index 4 reads back 0xBEEF. Assert reset mid-TX-frame → uart_tx=1, gpio_out=0, status=0x0002.

Source files
------------

// File: rtl/console_io_pkg.sv
// console_io shared definitions: register map,
// status bit positions and the UART FSM states.
package console_io_pkg;

   localparam logic [6:0] REG_CONSOLE   = 7'd0;
   localparam logic [6:0] REG_STATUS    = 7'd1;
   localparam logic [6:0] REG_CYCLES    = 7'd2;
   localparam logic [6:0] REG_GPIO_BASE = 7'd3;

   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_VALID  = 2;
   localparam int ST_TX_OVF    = 3;
   localparam int ST_RX_OVF    = 4;
   localparam int ST_FRAME_ERR = 5;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_e;

endpackage

// File: rtl/console_io_if.sv
// Core-side register port of the console/GPIO peripheral.
// master = ulisp core, slave = console_io.
interface console_io_if;

   logic [6:0]  register_index;
   logic        register_read;
   logic        register_write;
   logic [15:0] register_write_value;
   logic [15:0] register_read_value;

   modport master (
      output register_index,
      output register_read,
      output register_write,
      output register_write_value,
      input  register_read_value
   );

   modport slave (
      input  register_index,
      input  register_read,
      input  register_write,
      input  register_write_value,
      output register_read_value
   );

endinterface

// File: rtl/console_io_sync_fifo.sv
// Single-clock FIFO with show-ahead head; a push into a
// full FIFO is accepted when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = cnt_q == FULL_CNT;
   assign empty_o = cnt_q == '0;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rptr_q];
   assign level_o = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/console_io.sv
// Memory-mapped 8N1 UART console with TX/RX FIFOs,
// sticky error flags, cycle counter and GPIO outputs.
module console_io
   import console_io_pkg::*;
#(
   parameter int TX_DEPTH     = 16,
   parameter int RX_DEPTH     = 16,
   parameter int CLKS_PER_BIT = 868,
   parameter int NUM_GPIO     = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   console_io_if.slave            bus,
   output logic                   uart_tx,
   input  logic                   uart_rx,
   output logic [16*NUM_GPIO-1:0] gpio_out
);

   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

   logic [6:0]  idx;
   logic        rd;
   logic        wr;
   logic [15:0] wv;

   assign idx = bus.register_index;
   assign rd  = bus.register_read;
   assign wr  = bus.register_write;
   assign wv  = bus.register_write_value;

   logic         tx_push, tx_pop, txf_full, txf_empty;
   logic [7:0]   txf_dout;
   logic [TAW:0] txf_level;
   logic         rx_push, rx_pop, rxf_full, rxf_empty;
   logic [7:0]   rxf_dout;
   logic [RAW:0] unused_rx_level;

   uart_state_e tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        tx_end;

   uart_state_e rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   logic        rx_end, rx_fall, rx_done, frame_ev;

   logic        txovf_q, txovf_d;
   logic        rxovf_q, rxovf_d;
   logic        fe_q, fe_d;
   logic        w1c;
   logic [15:0] cyc_q;
   logic [15:0] rdata_q, rdata_d;
   logic [15:0] rd_mux;
   logic [15:0] status;
   logic [15:0] tx_lvl16;
   logic [15:0] gpio_q [NUM_GPIO];
   logic [15:0] gpio_d [NUM_GPIO];

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_i  (tx_push),
      .data_i  (wv[7:0]),
      .pop_i   (tx_pop),
      .data_o  (txf_dout),
      .full_o  (txf_full),
      .empty_o (txf_empty),
      .level_o (txf_level)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_i  (rx_push),
      .data_i  (rx_sh_q),
      .pop_i   (rx_pop),
      .data_o  (rxf_dout),
      .full_o  (rxf_full),
      .empty_o (rxf_empty),
      .level_o (unused_rx_level)
   );

   // ---------------- TX FSM
   assign tx_end = tx_cnt_q == BIT_END;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= UART_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      unique case (tx_state_q)
         UART_IDLE: begin
            tx_cnt_d = '0;
            if (!txf_empty) begin
               tx_state_d = UART_START;
               tx_sh_d    = txf_dout;
            end
         end
         UART_START: if (tx_end) begin
            tx_state_d = UART_DATA;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
         end
         UART_DATA: if (tx_end) begin
            tx_cnt_d = '0;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = UART_STOP;
         end
         UART_STOP: if (tx_end) begin
            tx_cnt_d = '0;
            // back-to-back frames reload straight into START
            if (!txf_empty) begin
               tx_state_d = UART_START;
               tx_sh_d    = txf_dout;
            end else begin
               tx_state_d = UART_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      uart_tx = 1'b1;
      tx_pop  = 1'b0;
      unique case (tx_state_q)
         UART_IDLE:  tx_pop  = !txf_empty;
         UART_START: uart_tx = 1'b0;
         UART_DATA:  uart_tx = tx_sh_q[0];
         UART_STOP:  tx_pop  = tx_end && !txf_empty;
      endcase
   end

   // ---------------- RX FSM
   assign rx_end  = rx_cnt_q == BIT_END;
   assign rx_fall = rx_prev_q && !rx_sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= UART_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
      end else begin
         rx_meta_q  <= uart_rx;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      unique case (rx_state_q)
         UART_IDLE: begin
            // the fall cycle itself counts toward the half bit
            rx_cnt_d = 16'd1;
            if (rx_fall) rx_state_d = UART_START;
         end
         UART_START: if (rx_cnt_q == HALF_END) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? UART_IDLE : UART_DATA;
         end
         UART_DATA: if (rx_end) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = UART_STOP;
         end
         UART_STOP: if (rx_end) begin
            rx_cnt_d   = '0;
            rx_state_d = UART_IDLE;
         end
      endcase
   end

   always_comb begin
      rx_done  = (rx_state_q == UART_STOP) && rx_end;
      rx_push  = rx_done && rx_sync_q;
      frame_ev = rx_done && !rx_sync_q;
   end

   // ---------------- register port
   assign tx_push  = wr && idx == REG_CONSOLE;
   assign rx_pop   = rd && idx == REG_CONSOLE;
   assign w1c      = wr && idx == REG_STATUS;
   assign tx_lvl16 = 16'(txf_level);

   always_comb begin
      txovf_d = (txovf_q && !(w1c && wv[ST_TX_OVF]))
              || (tx_push && txf_full && !tx_pop);
      rxovf_d = (rxovf_q && !(w1c && wv[ST_RX_OVF]))
              || (rx_push && rxf_full && !rx_pop);
      fe_d    = (fe_q && !(w1c && wv[ST_FRAME_ERR]))
              || frame_ev;
   end

   always_comb begin
      status               = '0;
      status[ST_TX_FULL]   = txf_full;
      status[ST_TX_EMPTY]  = txf_empty;
      status[ST_RX_VALID]  = !rxf_empty;
      status[ST_TX_OVF]    = txovf_q;
      status[ST_RX_OVF]    = rxovf_q;
      status[ST_FRAME_ERR] = fe_q;
      status[15:8] = (tx_lvl16 > 16'd255) ? 8'hFF : tx_lvl16[7:0];
   end

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         idx == REG_CONSOLE:
            rd_mux = rxf_empty ? 16'hFFFF : {8'h00, rxf_dout};
         idx == REG_STATUS: rd_mux = status;
         idx == REG_CYCLES: rd_mux = cyc_q;
         default: begin
            for (int k = 0; k < NUM_GPIO; k++) begin
               if (idx == REG_GPIO_BASE + 7'(k)) rd_mux = gpio_q[k];
            end
         end
      endcase
      rdata_d = rd ? rd_mux : rdata_q;
   end

   always_comb begin
      for (int k = 0; k < NUM_GPIO; k++) begin
         gpio_d[k] = gpio_q[k];
         if (wr && idx == REG_GPIO_BASE + 7'(k)) gpio_d[k] = wv;
      end
   end

   always_comb begin
      gpio_out = '0;
      for (int k = 0; k < NUM_GPIO; k++) gpio_out[16*k +: 16] = gpio_q[k];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txovf_q <= 1'b0;
         rxovf_q <= 1'b0;
         fe_q    <= 1'b0;
         cyc_q   <= '0;
         rdata_q <= '0;
         for (int k = 0; k < NUM_GPIO; k++) gpio_q[k] <= '0;
      end else begin
         txovf_q <= txovf_d;
         rxovf_q <= rxovf_d;
         fe_q    <= fe_d;
         cyc_q   <= cyc_q + 16'd1;
         rdata_q <= rdata_d;
         for (int k = 0; k < NUM_GPIO; k++) gpio_q[k] <= gpio_d[k];
      end
   end

   assign bus.register_read_value = rdata_q;

endmodule

// File: tb/tb_console_io.sv
// Self-checking bench for console_io: register vectors,
// UART frame sequences and a randomized model comparison.
module tb_console_io;

   localparam int CPB = 4;
   localparam int NG  = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic uart_tx;
   logic uart_rx = 1'b1;
   logic [16*NG-1:0] gpio_out;

   console_io_if bus();

   console_io #(
      .TX_DEPTH(4), .RX_DEPTH(4),
      .CLKS_PER_BIT(CPB), .NUM_GPIO(NG)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .uart_tx(uart_tx), .uart_rx(uart_rx),
      .gpio_out(gpio_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name,
                        input logic [39:0] act,
                        input logic [39:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // decodes uart_tx frames independently of the DUT internals
   logic [7:0] tx_got [$];
   int         tx_at [$];
   bit         mon_en = 1'b1;

   initial begin : tx_mon
      logic p;
      logic [7:0] b;
      int st;
      p = 1'b1;
      b = '0;
      forever begin
         @(negedge clk);
         if (p && uart_tx === 1'b0) begin
            st = cyc;
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (mon_en && uart_tx === 1'b1) begin
               tx_got.push_back(b);
               tx_at.push_back(st);
            end
         end
         p = uart_tx;
      end
   end

   task automatic reg_write(input logic [6:0] i, input logic [15:0] v);
      @(negedge clk);
      bus.register_index = i;
      bus.register_write_value = v;
      bus.register_write = 1'b1;
      @(negedge clk);
      bus.register_write = 1'b0;
   endtask

   task automatic reg_read(input logic [6:0] i,
                           output logic [15:0] v, output int at);
      @(negedge clk);
      bus.register_index = i;
      bus.register_read = 1'b1;
      @(negedge clk);
      bus.register_read = 1'b0;
      v = bus.register_read_value;
      at = cyc;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rx = f[i];
         repeat (CPB - 1) @(negedge clk);
      end
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB + 2) @(negedge clk);
   endtask

   task automatic wait_tx(input int n, input int limit, input string name);
      for (int c = 0; c < limit && tx_got.size() < n; c++)
         @(negedge clk);
      check(name, 40'(tx_got.size()), 40'(n));
   endtask

   typedef struct {
      string       name;
      logic        wr;
      logic [6:0]  idx;
      logic [15:0] wval;
      logic [15:0] exp_rd;
      logic [31:0] exp_gpio;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [15:0] v, v2;
      logic [39:0] cap, expf;
      logic [7:0]  b;
      logic [15:0] gpio_m [NG];
      logic [7:0]  rx_exp [$];
      int a1, a2, k, op;

      bus.register_index = '0;
      bus.register_read = 1'b0;
      bus.register_write = 1'b0;
      bus.register_write_value = '0;

      vecs[0] = '{"status_rst", 0, 7'd1, 16'h0, 16'h0002, 32'h0};
      vecs[1] = '{"rx_empty", 0, 7'd0, 16'h0, 16'hFFFF, 32'h0};
      vecs[2] = '{"gpio0", 1, 7'd3, 16'h1234, 16'h1234, 32'h0000_1234};
      vecs[3] = '{"gpio1", 1, 7'd4, 16'hBEEF, 16'hBEEF, 32'hBEEF_1234};
      vecs[4] = '{"idx5", 1, 7'd5, 16'h5555, 16'h0, 32'hBEEF_1234};
      vecs[5] = '{"idx127", 1, 7'd127, 16'hFFFF, 16'h0, 32'hBEEF_1234};
      vecs[6] = '{"gpio0_b", 1, 7'd3, 16'h1357, 16'h1357, 32'hBEEF_1357};
      vecs[7] = '{"w1c_idle", 1, 7'd1, 16'h003F, 16'h0002, 32'hBEEF_1357};
      vecs[8] = '{"idx6", 0, 7'd6, 16'h0, 16'h0, 32'hBEEF_1357};

      repeat (3) @(negedge clk);
      check("rst_tx", 40'(uart_tx), 40'h1);
      check("rst_gpio", 40'(gpio_out), 40'h0);
      check("rst_rdata", 40'(bus.register_read_value), 40'h0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            reg_write(vecs[i].idx, vecs[i].wval);
            check({vecs[i].name, "_gpio"}, 40'(gpio_out),
                  40'(vecs[i].exp_gpio));
         end
         reg_read(vecs[i].idx, v, a1);
         check(vecs[i].name, 40'(v), 40'(vecs[i].exp_rd));
      end

      // read and write on the same edge: old value is returned
      @(negedge clk);
      bus.register_index = 7'd3;
      bus.register_write_value = 16'h7777;
      bus.register_read = 1'b1;
      bus.register_write = 1'b1;
      @(negedge clk);
      bus.register_read = 1'b0;
      bus.register_write = 1'b0;
      check("rdwr_old", 40'(bus.register_read_value), 40'h1357);
      check("rdwr_gpio", 40'(gpio_out[15:0]), 40'h7777);
      reg_read(7'd3, v, a1);
      check("rdwr_new", 40'(v), 40'h7777);

      // single TX frame, captured bit by bit
      reg_write(7'd0, 16'h0041);
      check("tx_not_yet", 40'(uart_tx), 40'h1);
      b = 8'h41;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cap[i] = uart_tx;
         if (i < 4) expf[i] = 1'b0;
         else if (i < 36) expf[i] = b[(i - 4) / 4];
         else expf[i] = 1'b1;
      end
      check("tx_frame41", cap, expf);
      @(negedge clk);
      check("tx_idle_after", 40'(uart_tx), 40'h1);
      check("tx_mon41", 40'(tx_got.size() > 0 ? tx_got[0] : 8'h00),
            40'h41);
      tx_got.delete();
      tx_at.delete();
      reg_read(7'd1, v, a1);
      check("tx_empty_st", 40'(v), 40'h0002);

      // six back-to-back pushes into a depth-4 FIFO
      @(negedge clk);
      bus.register_index = 7'd0;
      bus.register_write = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.register_write_value = 16'(16'h30 + i);
         @(negedge clk);
      end
      bus.register_write = 1'b0;
      reg_read(7'd1, v, a1);
      check("burst_status", 40'(v), 40'h0409);
      wait_tx(5, 400, "burst_count");
      for (int i = 0; i < 5; i++) begin
         check("burst_byte",
               40'(i < tx_got.size() ? tx_got[i] : 8'hXX),
               40'(8'h30 + i));
         if (i > 0 && i < tx_at.size())
            check("burst_gap", 40'(tx_at[i] - tx_at[i-1]),
                  40'(10 * CPB));
      end
      tx_got.delete();
      tx_at.delete();
      repeat (4) @(negedge clk);
      reg_write(7'd1, 16'h0008);
      reg_read(7'd1, v, a1);
      check("txovf_clr", 40'(v), 40'h0002);

      // RX receive and pop
      send_rx(8'h5A, 1'b1);
      reg_read(7'd1, v, a1);
      check("rx_status", 40'(v), 40'h0006);
      reg_read(7'd0, v, a1);
      check("rx_5a", 40'(v), 40'h005A);
      reg_read(7'd0, v, a1);
      check("rx_empty2", 40'(v), 40'hFFFF);

      // framing error, then glitch
      send_rx(8'hA5, 1'b0);
      reg_read(7'd1, v, a1);
      check("frame_err", 40'(v), 40'h0022);
      reg_write(7'd1, 16'h0020);
      reg_read(7'd1, v, a1);
      check("fe_clr", 40'(v), 40'h0002);
      @(negedge clk);
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      reg_read(7'd1, v, a1);
      check("glitch", 40'(v), 40'h0002);

      // RX overflow
      for (int i = 0; i < 5; i++) send_rx(8'(8'h11 * (i + 1)), 1'b1);
      reg_read(7'd1, v, a1);
      check("rx_ovf_st", 40'(v), 40'h0016);
      for (int i = 0; i < 4; i++) begin
         reg_read(7'd0, v, a1);
         check("rx_ovf_byte", 40'(v), 40'(8'h11 * (i + 1)));
      end
      reg_read(7'd0, v, a1);
      check("rx_ovf_drain", 40'(v), 40'hFFFF);
      reg_write(7'd1, 16'h0010);
      reg_read(7'd1, v, a1);
      check("rxovf_clr", 40'(v), 40'h0002);

      // randomized operations against a register/queue model
      for (int i = 0; i < NG; i++) begin
         reg_write(7'(3 + i), 16'h0);
         gpio_m[i] = 16'h0;
      end
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 4);
         case (op)
            0: begin
               k = $urandom_range(0, NG - 1);
               v = 16'($urandom);
               reg_write(7'(3 + k), v);
               gpio_m[k] = v;
               check("rnd_gpio_out", 40'(gpio_out),
                     40'({gpio_m[1], gpio_m[0]}));
               reg_read(7'(3 + k), v2, a1);
               check("rnd_gpio_rd", 40'(v2), 40'(gpio_m[k]));
            end
            1: begin
               b = 8'($urandom);
               send_rx(b, 1'b1);
               rx_exp.push_back(b);
               reg_read(7'd0, v, a1);
               check("rnd_rx", 40'(v), 40'({8'h00, rx_exp.pop_front()}));
            end
            2: begin
               b = 8'($urandom);
               reg_write(7'd0, {8'($urandom), b});
               wait_tx(1, 100, "rnd_tx_cnt");
               if (tx_got.size() > 0)
                  check("rnd_tx", 40'(tx_got.pop_front()), 40'(b));
               tx_at.delete();
               repeat (3) @(negedge clk);
            end
            3: begin
               k = $urandom_range(5, 127);
               reg_write(7'(k), 16'($urandom));
               reg_read(7'(k), v, a1);
               check("rnd_badidx", 40'(v), 40'h0);
               check("rnd_badgpio", 40'(gpio_out),
                     40'({gpio_m[1], gpio_m[0]}));
            end
            default: begin
               reg_read(7'd2, v, a1);
               repeat ($urandom_range(0, 20)) @(negedge clk);
               reg_read(7'd2, v2, a2);
               check("rnd_cycles", 40'(16'(v2 - v)), 40'(16'(a2 - a1)));
            end
         endcase
      end

      // asynchronous reset in the middle of a TX frame
      reg_write(7'd3, 16'h1111);
      reg_read(7'd3, v, a1);
      mon_en = 1'b0;
      reg_write(7'd0, 16'h0055);
      @(negedge clk);
      check("mid_tx_low", 40'(uart_tx), 40'h0);
      #2 reset = 1'b1;
      #1;
      check("arst_tx", 40'(uart_tx), 40'h1);
      check("arst_gpio", 40'(gpio_out), 40'h0);
      check("arst_rdata", 40'(bus.register_read_value), 40'h0);
      @(negedge clk);
      reset = 1'b0;
      reg_read(7'd1, v, a1);
      check("arst_status", 40'(v), 40'h0002);
      reg_read(7'd0, v, a1);
      check("arst_rx", 40'(v), 40'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
